axi_uartlite_responder: RTL and testbench

AXI4-Lite responder that implements the UART-Lite register map (RX FIFO, TX FIFO, STAT, CTRL) over byte-stream ports instead of a serial line. It is the target end of the bus for the core's polling UART initiator: it serves STAT/RX reads and TX writes, and is used as the simulation and loopback peer of that initiator. Byte streams connect to a serializer/deserializer or directly to a bench.

---
 rtl/uartlite_pkg.sv | 27 ++
 rtl/uartlite_fifo.sv | 48 ++++
 rtl/axi_uartlite_responder.sv | 192 +++++++++++++++++++
 tb/tb_axi_uartlite_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uartlite_pkg.sv
// Register offsets and STAT/CTRL bit positions for the UART-Lite responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uartlite_pkg;

   // Register select, decoded from addr[3:2]
   typedef enum logic [1:0] {
      REG_RX   = 2'd0,
      REG_TX   = 2'd1,
      REG_STAT = 2'd2,
      REG_CTRL = 2'd3
   } reg_sel_e;

   // STAT bit positions
   localparam int STAT_RX_VALID = 0;
   localparam int STAT_RX_FULL  = 1;
   localparam int STAT_TX_EMPTY = 2;
   localparam int STAT_TX_FULL  = 3;
   localparam int STAT_IE       = 4;
   localparam int STAT_OVERRUN  = 5;

   // CTRL bit positions
   localparam int CTRL_RST_TX = 0;
   localparam int CTRL_RST_RX = 1;
   localparam int CTRL_IE     = 4;

endpackage

// File: rtl/uartlite_fifo.sv
// Byte FIFO with push/pop/flush; pointers carry an extra MSB to tell full from empty.
// Latency: push visible on head/empty one cycle later; head is combinational from the read pointer.
// Backpressure: push ignored when full, pop ignored when empty, flush overrides both.
// Ports: clk/rst (sync, active-high), push/push_data, pop, flush, head_data, full, empty.
module uartlite_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   input  logic       flush,
   output logic [7:0] head_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; it is only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/axi_uartlite_responder.sv
// AXI4-Lite target exposing the UART-Lite register map (RX, TX, STAT, CTRL) over byte streams.
// Latency: R one cycle after AR handshake; B and register effect one cycle after AW+W both accepted.
// Backpressure: AR stalls while R is pending, AW/W stall while held or B pending; rx bytes dropped when full.
// Ports: clk/rst (sync, active-high), s_axi_* AXI4-Lite target, rx_valid/rx_data inbound byte strobe,
//        tx_valid/tx_ready/tx_data outbound byte handshake, irq one-cycle interrupt pulse.
module axi_uartlite_responder
   import uartlite_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        irq
);

   // FIFO status
   logic       rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0] rx_head;
   logic       rx_pop, rx_flush, tx_push, tx_pop, tx_flush;

   // Control/status state
   logic       ie;
   logic       overrun;
   logic       rx_empty_q, tx_empty_q;

   // Write channel state
   logic       aw_held, w_held;
   reg_sel_e   awsel_q;
   logic [7:0] wdata_q;
   logic       wstrb0_q;

   logic       ar_hs, aw_hs, w_hs, do_write, ctrl_wr;
   reg_sel_e   rd_sel, wr_sel;
   logic [7:0] wr_data;
   logic       wr_strb0;
   logic [7:0] stat_now;

   // Only addr[3:2], wdata[7:0] and wstrb[0] are meaningful.
   logic unused_bits;
   assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_araddr[31:4],
                          s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1]};

   assign s_axi_bresp = 2'b00;
   assign s_axi_rresp = 2'b00;

   // ---------------- read path ----------------
   assign s_axi_arready = !s_axi_rvalid && !rst;
   assign ar_hs         = s_axi_arvalid && s_axi_arready;
   assign rd_sel        = reg_sel_e'(s_axi_araddr[3:2]);
   assign rx_pop        = ar_hs && (rd_sel == REG_RX) && !rx_empty;

   always_comb begin
      stat_now                = '0;
      stat_now[STAT_RX_VALID] = !rx_empty;
      stat_now[STAT_RX_FULL]  = rx_full;
      stat_now[STAT_TX_EMPTY] = tx_empty;
      stat_now[STAT_TX_FULL]  = tx_full;
      stat_now[STAT_IE]       = ie;
      stat_now[STAT_OVERRUN]  = overrun;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else if (ar_hs) begin
         s_axi_rvalid <= 1'b1;
         case (rd_sel)
            REG_RX:   s_axi_rdata <= rx_empty ? 32'd0 : {24'd0, rx_head};
            REG_STAT: s_axi_rdata <= {24'd0, stat_now};
            default:  s_axi_rdata <= '0;
         endcase
      end else if (s_axi_rvalid && s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   // ---------------- write path ----------------
   assign s_axi_awready = !aw_held && !s_axi_bvalid && !rst;
   assign s_axi_wready  = !w_held && !s_axi_bvalid && !rst;
   assign aw_hs         = s_axi_awvalid && s_axi_awready;
   assign w_hs          = s_axi_wvalid && s_axi_wready;

   // The held copy and a live handshake are mutually exclusive, so whichever exists is the beat.
   assign wr_sel   = aw_held ? awsel_q : reg_sel_e'(s_axi_awaddr[3:2]);
   assign wr_data  = w_held ? wdata_q : s_axi_wdata[7:0];
   assign wr_strb0 = w_held ? wstrb0_q : s_axi_wstrb[0];
   assign do_write = (aw_held || aw_hs) && (w_held || w_hs) && !s_axi_bvalid;

   assign tx_push  = do_write && (wr_sel == REG_TX) && wr_strb0;
   assign ctrl_wr  = do_write && (wr_sel == REG_CTRL) && wr_strb0;
   assign tx_flush = ctrl_wr && wr_data[CTRL_RST_TX];
   assign rx_flush = ctrl_wr && wr_data[CTRL_RST_RX];

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         awsel_q      <= REG_RX;
         wdata_q      <= '0;
         wstrb0_q     <= 1'b0;
         s_axi_bvalid <= 1'b0;
         ie           <= 1'b0;
      end else begin
         if (s_axi_bvalid && s_axi_bready) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               awsel_q <= reg_sel_e'(s_axi_awaddr[3:2]);
            end
            if (w_hs) begin
               w_held   <= 1'b1;
               wdata_q  <= s_axi_wdata[7:0];
               wstrb0_q <= s_axi_wstrb[0];
            end
            if (do_write) s_axi_bvalid <= 1'b1;
         end
         if (ctrl_wr) ie <= wr_data[CTRL_IE];
      end
   end

   // ---------------- byte streams ----------------
   assign tx_valid = !tx_empty && !rst;
   assign tx_pop   = tx_valid && tx_ready;

   uartlite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rx_pop),
      .flush     (rx_flush),
      .head_data (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   uartlite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (wr_data),
      .pop       (tx_pop),
      .flush     (tx_flush),
      .head_data (tx_data),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   // Overrun: a new drop wins over a same-cycle STAT read so no event is lost.
   // irq: edge detect on the registered FIFO empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun    <= 1'b0;
         rx_empty_q <= 1'b1;
         tx_empty_q <= 1'b1;
         irq        <= 1'b0;
      end else begin
         if (rx_valid && rx_full)                   overrun <= 1'b1;
         else if (ar_hs && (rd_sel == REG_STAT))    overrun <= 1'b0;
         rx_empty_q <= rx_empty;
         tx_empty_q <= tx_empty;
         irq        <= ie && ((rx_empty_q && !rx_empty) || (!tx_empty_q && tx_empty));
      end
   end

endmodule

// File: tb/tb_axi_uartlite_responder.sv
// Directed bench for axi_uartlite_responder: register map, FIFO boundaries, handshake ordering, irq, reset.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: bench drives tx_ready/bready/rready explicitly per step.
module tb_axi_uartlite_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [3:0]  s_axi_wstrb;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready;
   logic        rx_valid, tx_valid, tx_ready, irq;
   logic [7:0]  rx_data, tx_data;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;
   logic [7:0]  tx_got [32];
   int          tx_n;
   int          n;

   always #5 clk = ~clk;

   axi_uartlite_responder #(.FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .irq(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AR handshake, then R must be valid exactly one cycle later.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      int k;
      @(negedge clk);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      k = 0;
      while (!s_axi_arready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("ar_accept_in_time", 32'(k < 50), 32'd1);
      @(negedge clk);
      s_axi_arvalid = 1'b0;
      check("rvalid_one_cycle_after_ar", 32'(s_axi_rvalid), 32'd1);
      check("rresp_okay", 32'(s_axi_rresp), 32'd0);
      data = s_axi_rdata;
      s_axi_rready = 1'b1;
      @(negedge clk);
      s_axi_rready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int  k;
      logic aw_go, w_go;
      @(negedge clk);
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = 1'b1;
      k = 0;
      while ((s_axi_awvalid || s_axi_wvalid) && k < 50) begin
         aw_go = s_axi_awvalid && s_axi_awready;
         w_go  = s_axi_wvalid && s_axi_wready;
         @(negedge clk);
         if (aw_go) s_axi_awvalid = 1'b0;
         if (w_go)  s_axi_wvalid  = 1'b0;
         k++;
      end
      k = 0;
      while (!s_axi_bvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("bvalid_in_time", 32'(s_axi_bvalid), 32'd1);
      check("bresp_okay", 32'(s_axi_bresp), 32'd0);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b1;
      @(negedge clk);
      s_axi_bready  = 1'b0;
   endtask

   // B must stay up for 4 cycles with bready low, then retire after one handshake.
   task automatic hold_b(input string tag);
      for (int i = 0; i < 4; i++) begin
         check(tag, 32'(s_axi_bvalid), 32'd1);
         @(negedge clk);
      end
      s_axi_bready = 1'b1;
      @(negedge clk);
      s_axi_bready = 1'b0;
      check("bvalid_drops_after_b", 32'(s_axi_bvalid), 32'd0);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Open tx_ready and collect every byte that leaves.
   task automatic drain_tx();
      tx_n     = 0;
      tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (tx_valid && tx_n < 32) begin
            tx_got[tx_n] = tx_data;
            tx_n++;
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_arready", 32'(s_axi_arready), 32'd0);
      check("rst_awready", 32'(s_axi_awready), 32'd0);
      check("rst_wready",  32'(s_axi_wready),  32'd0);
      check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
      check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", s_axi_rdata, 32'd0);
      rst = 1'b0;

      // ---- STAT after reset, single TX write ----
      axi_read(32'h8, rd);
      check("stat_after_reset", rd, 32'h4);
      axi_write(32'h4, 32'h41, 4'hF);
      check("tx_valid_after_write", 32'(tx_valid), 32'd1);
      check("tx_data_after_write", 32'(tx_data), 32'h41);
      axi_read(32'h8, rd);
      check("stat_tx_nonempty", rd, 32'h0);
      drain_tx();
      check("drain1_count", tx_n, 1);
      check("drain1_byte", 32'(tx_got[0]), 32'h41);

      // ---- RX two bytes ----
      rx_byte(8'h55);
      rx_byte(8'h66);
      axi_read(32'h8, rd);
      check("stat_rx_two", rd, 32'h5);
      axi_read(32'h0, rd);
      check("rx_first", rd, 32'h55);
      axi_read(32'h0, rd);
      check("rx_second", rd, 32'h66);
      axi_read(32'h0, rd);
      check("rx_empty_read", rd, 32'h0);
      axi_read(32'h8, rd);
      check("stat_rx_drained", rd, 32'h4);

      // ---- RX overrun: 17 bytes into 16 entries ----
      for (int i = 0; i < 17; i++) rx_byte(8'(8'h10 + i));
      axi_read(32'h8, rd);
      check("stat_overrun", rd, 32'h27);
      axi_read(32'h8, rd);
      // still non-empty + full + TX empty; overrun cleared by the previous read
      check("stat_overrun_cleared", rd, 32'h07);
      for (int i = 0; i < 16; i++) begin
         axi_read(32'h0, rd);
         check("rx_overrun_order", rd, 32'h10 + 32'(i));
      end
      axi_read(32'h8, rd);
      check("stat_after_rx_drain", rd, 32'h4);

      // ---- TX full: 17 writes with tx_ready low ----
      for (int i = 0; i < 16; i++) axi_write(32'h4, 32'h80 + 32'(i), 4'hF);
      axi_read(32'h8, rd);
      check("stat_tx_full", rd, 32'h8);
      axi_write(32'h4, 32'hEE, 4'hF);
      axi_read(32'h8, rd);
      check("stat_tx_full_after_drop", rd, 32'h8);
      axi_write(32'h4, 32'h33, 4'hE);   // byte lane 0 disabled
      drain_tx();
      check("drain16_count", tx_n, 16);
      for (int i = 0; i < 16; i++) check("drain16_order", 32'(tx_got[i]), 32'h80 + 32'(i));

      // ---- W before AW, then AW+W together ----
      @(negedge clk);
      s_axi_wdata = 32'hA1; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
      check("w_first_wready", 32'(s_axi_wready), 32'd1);
      @(negedge clk);
      s_axi_wvalid = 1'b0;
      repeat (3) begin
         check("w_held_no_wready", 32'(s_axi_wready), 32'd0);
         check("w_held_no_bvalid", 32'(s_axi_bvalid), 32'd0);
         @(negedge clk);
      end
      s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
      check("aw_late_awready", 32'(s_axi_awready), 32'd1);
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      hold_b("b_hold_w_first");
      s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hA2; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
      check("same_cycle_ready", 32'(s_axi_awready && s_axi_wready), 32'd1);
      @(negedge clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      hold_b("b_hold_same_cycle");
      check("tx_head_a1", 32'(tx_data), 32'hA1);
      drain_tx();
      check("drain2_count", tx_n, 2);
      check("drain2_b0", 32'(tx_got[0]), 32'hA1);
      check("drain2_b1", 32'(tx_got[1]), 32'hA2);

      // ---- CTRL flush + interrupt enable ----
      rx_byte(8'h77);
      axi_write(32'h4, 32'h99, 4'hF);
      axi_write(32'hC, 32'h13, 4'hF);
      axi_read(32'h8, rd);
      check("stat_after_ctrl", rd, 32'h14);
      repeat (2) @(negedge clk);
      check("irq_idle", 32'(irq), 32'd0);
      rx_byte(8'h5A);
      n = 0;
      while (!irq && n < 5) begin
         @(negedge clk);
         n++;
      end
      check("irq_on_rx", 32'(irq), 32'd1);
      @(negedge clk);
      check("irq_one_cycle", 32'(irq), 32'd0);

      // ---- reset in the middle of a read ----
      s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
      @(negedge clk);
      s_axi_arvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rvalid", 32'(s_axi_rvalid), 32'd0);
      check("midrst_rdata", s_axi_rdata, 32'd0);
      check("midrst_arready", 32'(s_axi_arready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         check("postrst_no_r", 32'(s_axi_rvalid), 32'd0);
         @(negedge clk);
      end
      axi_read(32'h8, rd);
      check("stat_after_midrst", rd, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
